mux2_arb: RTL
=============

MUX2_ARB -- requirements
Module: mux2_arb

Interface
REQ-001 Parameter W, default 8: data width of each input and of the output.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 i0  input  W  data from requester 0.
REQ-005 i1  input  W  data from requester 1.
REQ-006 v0  input  1  requester 0 valid.
REQ-007 v1  input  1  requester 1 valid.
REQ-008 g0  output  1  requester 0 granted; a transfer occurs in any cycle where v0 and g0 are both 1.
REQ-009 g1  output  1  requester 1 granted; a transfer occurs in any cycle where v1 and g1 are both 1.
REQ-010 j  output  1  current mux select: 0 selects i0, 1 selects i1.
REQ-011 o  output  W  registered output data.
REQ-012 ov  output  1  output valid.
REQ-013 ordy  input  1  downstream ready; a beat drains in any cycle where ov and ordy are both 1.

Function
REQ-014 States SHALL be EMPTY (ov=0) and FULL (ov=1); the output register SHALL hold exactly one beat.
REQ-015 can_load = EMPTY or (FULL and ordy).
- g0 and g1 SHALL be 0 whenever can_load is 0.
REQ-016 Grants SHALL be combinational from v0, v1, can_load and the priority pointer lp (last port served).
- At most one of g0 and g1 SHALL be 1.
REQ-017 When can_load is 1:
- only v0 set: g0=1.
- only v1 set: g1=1.
- both set: grant port !lp.
- neither set: no grant.
REQ-018 j SHALL equal the selected port when a grant is issued; otherwise j SHALL hold the value of lp.
REQ-019 Data SHALL be chosen through the 2:1 mux (i0/i1 by j).
- On a transfer, o SHALL load the mux output at the next edge.
- On a transfer, ov SHALL be 1 at the next edge.
- Latency from input to output SHALL be 1 cycle.
REQ-020 On a transfer, lp SHALL update to the granted port; otherwise lp SHALL hold.
REQ-021 FULL with ordy=1 and a transfer: drain and load SHALL occur in the same cycle; the state SHALL stay FULL, so full throughput is 1 beat per cycle.
REQ-022 FULL with ordy=1 and no transfer: the state SHALL go to EMPTY (ov=0); o SHALL hold its last value.
REQ-023 FULL with ordy=0: o and ov SHALL be held stable; no grants SHALL be issued.
REQ-024 With both ports continuously valid and ordy=1, grants SHALL alternate 0,1,0,1...; neither port SHALL wait more than one transfer.

Reset
REQ-025 While rst_n=0, the block SHALL hold ov=0, o=0, lp=1, and state EMPTY.
- Consequence: port 0 wins the first contention after reset.
REQ-026 Reset asserted mid-transfer SHALL discard the held beat immediately (asynchronously); no grant SHALL be issued while rst_n=0.
REQ-027 The first grant after reset SHALL be issued in the first cycle after rst_n deasserts.

Structure
REQ-028 A shared package mux2_pkg SHALL hold:
- the state enum (EMPTY, FULL);
- port index constants P0=0 and P1=1;
- the default width constant DEF_W=8.
REQ-029 The data path SHALL instantiate the existing mux2 sub-module (ports i0, i1, j, o), one instance per data bit or W-wide variant; arbitration and storage SHALL stay in mux2_arb.

Verification
REQ-030 Reset check: rst_n=0 for 3 cycles, then release. Required: ov=0, o=0, g0=g1=0 while in reset; j=1 (lp) after release with no requests.
REQ-031 Single port: v0=1, i0=8'hA5, ordy=1. Required: g0=1, j=0; next cycle ov=1, o=8'hA5.
REQ-032 Contention: v0=v1=1, i0=8'h11, i1=8'h22, ordy=1 for 4 cycles after reset. Required: o sequence 11,22,11,22; j alternates 0,1,0,1.
REQ-033 Backpressure: load 8'h3C, then ordy=0 for 5 cycles with v1=1. Required: o=8'h3C and ov=1 held stable; g1=0. Then ordy=1. Required: g1=1 in that same cycle; o=i1 on the next edge.
REQ-034 Drain to empty: FULL, ordy=1, v0=v1=0. Required: ov=0 next cycle, o unchanged, lp unchanged.
REQ-035 Reset mid-operation: FULL with ordy=0, assert rst_n=0 between clock edges. Required: ov=0 and o=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/mux2_pkg.sv
// Shared types and constants for the two-input arbitrated mux slice.
package mux2_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  localparam logic        P0    = 1'b0;
  localparam logic        P1    = 1'b1;
  localparam int unsigned DEF_W = 8;

endpackage

// File: rtl/mux2.sv
// W-wide 2:1 multiplexer: j=0 selects i0, j=1 selects i1.
module mux2 #(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0] i0,
  input  logic [W-1:0] i1,
  input  logic         j,
  output logic [W-1:0] o
);

  always_comb begin
    o = j ? i1 : i0;
  end

endmodule

// File: rtl/mux2_arb.sv
// Two-requester round-robin arbiter feeding a one-beat registered output stage.
module mux2_arb
  import mux2_pkg::*;
#(
  parameter int unsigned W = DEF_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] i0,
  input  logic [W-1:0] i1,
  input  logic         v0,
  input  logic         v1,
  output logic         g0,
  output logic         g1,
  output logic         j,
  output logic [W-1:0] o,
  output logic         ov,
  input  logic         ordy
);

  state_t         state_q, state_d;
  logic           lp_q;
  logic [W-1:0]   mux_o;
  logic           can_load;
  logic           xfer;

  mux2 #(.W(W)) u_mux2 (
    .i0 (i0),
    .i1 (i1),
    .j  (j),
    .o  (mux_o)
  );

  // rst_n gates grants so nothing is offered while reset is held low
  always_comb begin
    can_load = rst_n & ((state_q == EMPTY) | ordy);
    g0       = 1'b0;
    g1       = 1'b0;
    if (can_load) begin
      if (v0 && v1) begin
        g0 = (lp_q == P1);
        g1 = (lp_q == P0);
      end else begin
        g0 = v0;
        g1 = v1;
      end
    end
    xfer = (v0 & g0) | (v1 & g1);
    if (g1)      j = P1;
    else if (g0) j = P0;
    else         j = lp_q;
  end

  always_comb begin
    state_d = state_q;
    if (xfer)                            state_d = FULL;
    else if (state_q == FULL && ordy)    state_d = EMPTY;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o    <= '0;
      lp_q <= P1;
    end else if (xfer) begin
      o    <= mux_o;
      lp_q <= g1;
    end
  end

  assign ov = (state_q == FULL);

endmodule
